// File: rtl/cave_pkg.sv
// Shared types and constants for the DDR upload (read-back) path.
package cave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        PF_REQ,
        PF_WAIT
    } state_t;

    localparam int unsigned DDR_BURST_LEN      = 1;
    localparam int unsigned HALFWORDS_PER_LINE = 4;
    localparam int unsigned HW_SEL_W           = $clog2(HALFWORDS_PER_LINE);

    // Halfword 0 is the least significant 16 bits of the line.
    function automatic logic [15:0] get_halfword(input logic [63:0] data,
                                                 input logic [HW_SEL_W-1:0] sel);
        return data[{sel, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/ddr_upload_line_buf.sv
// One cached 64-bit DDR line: tag/valid/data storage, hit compare and halfword mux.
module ddr_upload_line_buf
    import cave_pkg::*;
#(
    parameter int unsigned TAG_WIDTH = 22
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 inval,
    input  logic                 fill,
    input  logic [TAG_WIDTH-1:0] fill_tag,
    input  logic [63:0]          fill_data,
    input  logic [TAG_WIDTH-1:0] lookup_tag,
    input  logic [HW_SEL_W-1:0]  sel,
    output logic                 hit,
    output logic [15:0]          halfword
);

    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic [63:0]          data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end
    end

    always_comb begin
        hit      = valid & (tag == lookup_tag);
        halfword = get_halfword(data, sel);
    end

endmodule

// File: rtl/ddr_upload.sv
// Serves HPS ioctl upload reads from the DDR3 game region through a one-line cache.
// Define UPLOAD_PREFETCH_EN to add a second line buffer fed by a next-line prefetch.
module ddr_upload
    import cave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 25,
    parameter logic [31:0] DDR_BASE   = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_upload_cs,
    input  logic                  io_upload_rd,
    input  logic [ADDR_WIDTH-1:0] io_upload_addr,
    output logic [15:0]           io_upload_din,
    output logic                  io_upload_waitReq,
    output logic                  io_ddr_rd,
    output logic [31:0]           io_ddr_addr,
    output logic [7:0]            io_ddr_burstLength,
    input  logic                  io_ddr_waitReq,
    input  logic                  io_ddr_valid,
    input  logic [63:0]           io_ddr_dout
);

    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - 3;

    state_t                state;
    logic                  cs_q;
    logic                  aborted;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [HW_SEL_W-1:0]   sel_q;
    logic [TAG_WIDTH-1:0]  line;
    logic [HW_SEL_W-1:0]   sel;
    logic                  cs_rise, can_accept, accept, hit, miss, discard;
    logic [15:0]           hit_hw;
    logic                  fill0, hit0;
    logic [15:0]           hw0;
    logic                  unused_addr0;
`ifdef UPLOAD_PREFETCH_EN
    logic                  fill1, inval1, hit1, pending, want_pend, pend_hit;
    logic [15:0]           hw1;
    logic [TAG_WIDTH-1:0]  pf_tag, pend_tag, want_tag;
    logic [HW_SEL_W-1:0]   pend_sel, want_sel;
`endif

    function automatic logic [31:0] line_addr(input logic [TAG_WIDTH-1:0] l);
        return DDR_BASE + 32'({l, 3'b000});
    endfunction

    assign unused_addr0       = io_upload_addr[0];
    assign io_ddr_burstLength = 8'(DDR_BURST_LEN);

    // Lookup, accept and stall decode; waitReq must rise in the same cycle as a missing rd.
    always_comb begin
        line    = io_upload_addr[ADDR_WIDTH-1:3];
        sel     = io_upload_addr[2:1];
        cs_rise = io_upload_cs & ~cs_q;
        discard = aborted | ~io_upload_cs;
`ifdef UPLOAD_PREFETCH_EN
        can_accept = ((state == IDLE) || (state == PF_REQ) || (state == PF_WAIT)) && !pending;
        hit        = (hit0 | hit1) & ~cs_rise;
        hit_hw     = hit0 ? hw0 : hw1;
        fill1      = (state == PF_WAIT) & io_ddr_valid & ~discard;
`else
        can_accept = (state == IDLE);
        hit        = hit0 & ~cs_rise;
        hit_hw     = hw0;
`endif
        accept = io_upload_cs & io_upload_rd & can_accept;
        miss   = accept & ~hit;
        fill0  = (state == WAIT) & io_ddr_valid & ~discard;
`ifdef UPLOAD_PREFETCH_EN
        inval1    = cs_rise | fill0;
        want_pend = pending | miss;
        want_tag  = pending ? pend_tag : line;
        want_sel  = pending ? pend_sel : sel;
        pend_hit  = want_pend & (want_tag == pf_tag);
        io_upload_waitReq = (state == REQ) | (state == WAIT) | pending | miss;
`else
        io_upload_waitReq = (state != IDLE) | miss;
`endif
    end

    ddr_upload_line_buf #(.TAG_WIDTH(TAG_WIDTH)) u_buf0 (
        .clock      (clock),
        .reset      (reset),
        .inval      (cs_rise),
        .fill       (fill0),
        .fill_tag   (tag_q),
        .fill_data  (io_ddr_dout),
        .lookup_tag (line),
        .sel        (sel),
        .hit        (hit0),
        .halfword   (hw0)
    );

`ifdef UPLOAD_PREFETCH_EN
    ddr_upload_line_buf #(.TAG_WIDTH(TAG_WIDTH)) u_buf1 (
        .clock      (clock),
        .reset      (reset),
        .inval      (inval1),
        .fill       (fill1),
        .fill_tag   (pf_tag),
        .fill_data  (io_ddr_dout),
        .lookup_tag (line),
        .sel        (sel),
        .hit        (hit1),
        .halfword   (hw1)
    );
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cs_q          <= 1'b0;
            aborted       <= 1'b0;
            tag_q         <= '0;
            sel_q         <= '0;
            io_upload_din <= '0;
            io_ddr_rd     <= 1'b0;
            io_ddr_addr   <= '0;
`ifdef UPLOAD_PREFETCH_EN
            pending       <= 1'b0;
            pf_tag        <= '0;
            pend_tag      <= '0;
            pend_sel      <= '0;
`endif
        end else begin
            cs_q <= io_upload_cs;
            // A fetch outstanding while the session closes must not update the cache or din.
            if (!io_upload_cs && state != IDLE) aborted <= 1'b1;
`ifdef UPLOAD_PREFETCH_EN
            if (state == PF_REQ || state == PF_WAIT) begin
                if (accept && hit) io_upload_din <= hit_hw;
                else if (miss) begin
                    pending  <= 1'b1;
                    pend_tag <= line;
                    pend_sel <= sel;
                end
            end
`endif
            case (state)
                IDLE: begin
                    if (accept && hit) begin
                        io_upload_din <= hit_hw;
                    end else if (miss) begin
                        tag_q       <= line;
                        sel_q       <= sel;
                        aborted     <= 1'b0;
                        io_ddr_rd   <= 1'b1;
                        io_ddr_addr <= line_addr(line);
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (!io_ddr_waitReq) begin
                        io_ddr_rd <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (io_ddr_valid) begin
                        state <= IDLE;
                        if (fill0) begin
                            io_upload_din <= get_halfword(io_ddr_dout, sel_q);
`ifdef UPLOAD_PREFETCH_EN
                            pf_tag      <= TAG_WIDTH'(tag_q + 1'b1);
                            io_ddr_rd   <= 1'b1;
                            io_ddr_addr <= line_addr(TAG_WIDTH'(tag_q + 1'b1));
                            aborted     <= 1'b0;
                            state       <= PF_REQ;
`endif
                        end
                    end
                end
`ifdef UPLOAD_PREFETCH_EN
                PF_REQ: begin
                    if (!io_ddr_waitReq) begin
                        io_ddr_rd <= 1'b0;
                        state     <= PF_WAIT;
                    end
                end
                PF_WAIT: begin
                    // A rd parked behind the prefetch is either served by it or issued next.
                    if (io_ddr_valid) begin
                        pending <= 1'b0;
                        state   <= IDLE;
                        if (!discard && pend_hit) begin
                            io_upload_din <= get_halfword(io_ddr_dout, want_sel);
                        end else if (!discard && want_pend) begin
                            tag_q       <= want_tag;
                            sel_q       <= want_sel;
                            aborted     <= 1'b0;
                            io_ddr_rd   <= 1'b1;
                            io_ddr_addr <= line_addr(want_tag);
                            state       <= REQ;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_upload.sv
// Scoreboard bench for ddr_upload (default build) with a latency/backpressure DDR model.
module tb_ddr_upload;

    localparam int unsigned AW   = 25;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_upload_cs = 1'b0;
    logic          io_upload_rd = 1'b0;
    logic [AW-1:0] io_upload_addr = '0;
    logic [15:0]   io_upload_din;
    logic          io_upload_waitReq;
    logic          io_ddr_rd;
    logic [31:0]   io_ddr_addr;
    logic [7:0]    io_ddr_burstLength;
    logic          io_ddr_waitReq = 1'b0;
    logic          io_ddr_valid = 1'b0;
    logic [63:0]   io_ddr_dout = '0;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    int          bp_left = 0;
    int          ret_lat = 5;
    int          ret_cnt = -1;
    logic [63:0] ret_data = '0;
    int          accepts = 0;
    int          valids = 0;
    int          held_cycles = 0;
    int          instab = 0;
    bit          prev_held = 0;
    logic [31:0] prev_addr = '0;
    logic [31:0] acc_addr = '0;

    ddr_upload #(.ADDR_WIDTH(AW), .DDR_BASE(BASE)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_upload_cs       (io_upload_cs),
        .io_upload_rd       (io_upload_rd),
        .io_upload_addr     (io_upload_addr),
        .io_upload_din      (io_upload_din),
        .io_upload_waitReq  (io_upload_waitReq),
        .io_ddr_rd          (io_ddr_rd),
        .io_ddr_addr        (io_ddr_addr),
        .io_ddr_burstLength (io_ddr_burstLength),
        .io_ddr_waitReq     (io_ddr_waitReq),
        .io_ddr_valid       (io_ddr_valid),
        .io_ddr_dout        (io_ddr_dout)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] mem_read(input logic [31:0] a);
        if (a == BASE + 32'h10) return 64'h4444_3333_2222_1111;
        return {a ^ 32'hA5A5_5A5A, ~a};
    endfunction

    function automatic logic [15:0] exp_hw(input logic [AW-1:0] addr);
        logic [63:0] w;
        w = mem_read(BASE + {7'd0, addr[AW-1:3], 3'b000});
        return w[{addr[2:1], 4'b0000} +: 16];
    endfunction

    // Request acceptance and hold-stability monitor.
    always @(posedge clock) begin
        if (!reset) begin
            if (prev_held && (io_ddr_rd !== 1'b1 || io_ddr_addr !== prev_addr)) instab++;
            prev_held = io_ddr_rd && io_ddr_waitReq;
            prev_addr = io_ddr_addr;
            if (io_ddr_rd && io_ddr_waitReq) held_cycles++;
            if (io_ddr_rd && !io_ddr_waitReq) begin
                accepts++;
                acc_addr = io_ddr_addr;
                ret_data = mem_read(io_ddr_addr);
                ret_cnt  = ret_lat;
            end
        end else begin
            prev_held = 0;
        end
    end

    // DDR responder: backpressure and delayed single-beat return.
    always @(negedge clock) begin
        io_ddr_valid = 1'b0;
        if (ret_cnt > 0) ret_cnt--;
        if (ret_cnt == 0) begin
            io_ddr_valid = 1'b1;
            io_ddr_dout  = ret_data;
            ret_cnt      = -1;
            valids++;
        end
        if (io_ddr_rd === 1'b1 && bp_left > 0) begin
            io_ddr_waitReq = 1'b1;
            bp_left--;
        end else begin
            io_ddr_waitReq = 1'b0;
        end
    end

    task automatic do_read(input logic [AW-1:0] addr, output logic wr0, output logic [15:0] din,
                           output int waited, output int nreq);
        int acc0;
        exp_q.push_back(exp_hw(addr));
        acc0 = accepts;
        io_upload_addr = addr;
        io_upload_rd   = 1'b1;
        #1 wr0 = io_upload_waitReq;
        @(negedge clock);
        io_upload_rd = 1'b0;
        #1;
        waited = 0;
        while (io_upload_waitReq !== 1'b0 && waited < 200) begin
            @(negedge clock);
            #1;
            waited++;
        end
        din  = io_upload_din;
        nreq = accepts - acc0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        #1;
        checks++; if (io_upload_din !== 16'h0) begin failures++; $display("FAIL reset_din got=%h exp=0", io_upload_din); end
        checks++; if (io_upload_waitReq !== 1'b0) begin failures++; $display("FAIL reset_waitreq got=%b exp=0", io_upload_waitReq); end
        checks++; if (io_ddr_rd !== 1'b0) begin failures++; $display("FAIL reset_ddr_rd got=%b exp=0", io_ddr_rd); end
        checks++; if (io_ddr_addr !== 32'h0) begin failures++; $display("FAIL reset_ddr_addr got=%h exp=0", io_ddr_addr); end
        checks++; if (io_ddr_burstLength !== 8'd1) begin failures++; $display("FAIL burst_len got=%0d exp=1", io_ddr_burstLength); end
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        logic wr0; logic [15:0] din, exp; int waited, nreq;
        io_upload_cs = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        do_read(25'h10, wr0, din, waited, nreq);
        exp = exp_q.pop_front();
        checks++; if (wr0 !== 1'b1) begin failures++; $display("FAIL cold_waitreq_same_cycle got=%b exp=1", wr0); end
        checks++; if (din !== exp) begin failures++; $display("FAIL cold_din got=%h exp=%h", din, exp); end
        checks++; if (nreq != 1) begin failures++; $display("FAIL cold_requests got=%0d exp=1", nreq); end
        checks++; if (acc_addr !== BASE + 32'h10) begin failures++; $display("FAIL cold_ddr_addr got=%h exp=%h", acc_addr, BASE + 32'h10); end
        checks++; if (waited < 5 || waited >= 200) begin failures++; $display("FAIL cold_wait_cycles got=%0d exp=5..199", waited); end
    endtask

    task automatic test_hit();
        logic wr0; logic [15:0] din, exp; int waited, nreq;
        logic [AW-1:0] addrs[3];
        addrs[0] = 25'h12; addrs[1] = 25'h14; addrs[2] = 25'h16;
        foreach (addrs[i]) begin
            do_read(addrs[i], wr0, din, waited, nreq);
            exp = exp_q.pop_front();
            checks++; if (din !== exp) begin failures++; $display("FAIL hit_din[%0d] got=%h exp=%h", i, din, exp); end
            checks++; if (wr0 !== 1'b0 || waited != 0) begin failures++; $display("FAIL hit_stall[%0d] got=%b/%0d exp=0/0", i, wr0, waited); end
            checks++; if (nreq != 0) begin failures++; $display("FAIL hit_requests[%0d] got=%0d exp=0", i, nreq); end
        end
    endtask

    task automatic test_backpressure();
        logic wr0; logic [15:0] din, exp; int waited, nreq, h0, i0;
        h0 = held_cycles; i0 = instab;
        bp_left = 10;
        do_read(25'h28, wr0, din, waited, nreq);
        exp = exp_q.pop_front();
        checks++; if (wr0 !== 1'b1) begin failures++; $display("FAIL bp_waitreq got=%b exp=1", wr0); end
        checks++; if (nreq != 1) begin failures++; $display("FAIL bp_requests got=%0d exp=1", nreq); end
        checks++; if (held_cycles - h0 != 10) begin failures++; $display("FAIL bp_held_cycles got=%0d exp=10", held_cycles - h0); end
        checks++; if (instab != i0) begin failures++; $display("FAIL bp_stability got=%0d exp=%0d", instab, i0); end
        checks++; if (acc_addr !== BASE + 32'h28) begin failures++; $display("FAIL bp_ddr_addr got=%h exp=%h", acc_addr, BASE + 32'h28); end
        checks++; if (din !== exp) begin failures++; $display("FAIL bp_din got=%h exp=%h", din, exp); end
    endtask

    task automatic test_cs_gate();
        logic wr0; logic [15:0] din, exp, din0; int waited, nreq, acc0;
        din0 = io_upload_din; acc0 = accepts;
        io_upload_cs = 1'b0;
        @(negedge clock);
        io_upload_addr = 25'h10; io_upload_rd = 1'b1;
        #1;
        checks++; if (io_upload_waitReq !== 1'b0) begin failures++; $display("FAIL csoff_waitreq got=%b exp=0", io_upload_waitReq); end
        @(negedge clock);
        io_upload_rd = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (accepts != acc0 || io_upload_din !== din0) begin failures++; $display("FAIL csoff_ignored got=%0d/%h exp=%0d/%h", accepts, io_upload_din, acc0, din0); end
        io_upload_cs = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        do_read(25'h2A, wr0, din, waited, nreq);
        exp = exp_q.pop_front();
        checks++; if (wr0 !== 1'b1 || nreq != 1) begin failures++; $display("FAIL csrise_invalidate got=%b/%0d exp=1/1", wr0, nreq); end
        checks++; if (din !== exp) begin failures++; $display("FAIL csrise_din got=%h exp=%h", din, exp); end
    endtask

    task automatic test_abort();
        logic wr0; logic [15:0] din, exp, din0; int waited, nreq, acc0, v0, n;
        din0 = io_upload_din; acc0 = accepts;
        io_upload_addr = 25'h40; io_upload_rd = 1'b1;
        @(negedge clock);
        io_upload_rd = 1'b0;
        n = 0;
        while (accepts == acc0 && n < 50) begin @(negedge clock); n++; end
        #1;
        v0 = valids;
        io_upload_cs = 1'b0;
        n = 0;
        while (valids == v0 && n < 50) begin @(negedge clock); n++; end
        repeat (2) @(negedge clock);
        #1;
        checks++; if (valids == v0) begin failures++; $display("FAIL abort_valid_timeout got=%0d exp>%0d", valids, v0); end
        checks++; if (io_upload_din !== din0) begin failures++; $display("FAIL abort_din got=%h exp=%h", io_upload_din, din0); end
        checks++; if (io_upload_waitReq !== 1'b0) begin failures++; $display("FAIL abort_waitreq got=%b exp=0", io_upload_waitReq); end
        io_upload_cs = 1'b1;
        do_read(25'h40, wr0, din, waited, nreq);
        exp = exp_q.pop_front();
        checks++; if (wr0 !== 1'b1 || nreq != 1) begin failures++; $display("FAIL abort_refetch got=%b/%0d exp=1/1", wr0, nreq); end
        checks++; if (din !== exp) begin failures++; $display("FAIL abort_din_after got=%h exp=%h", din, exp); end
    endtask

    task automatic test_reset_mid_fetch();
        logic wr0; logic [15:0] din, exp; int waited, nreq;
        bp_left = 50;
        io_upload_addr = 25'h80; io_upload_rd = 1'b1;
        @(negedge clock);
        io_upload_rd = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        bp_left = 0;
        #1;
        checks++; if (io_upload_din !== 16'h0) begin failures++; $display("FAIL midrst_din got=%h exp=0", io_upload_din); end
        checks++; if (io_upload_waitReq !== 1'b0) begin failures++; $display("FAIL midrst_waitreq got=%b exp=0", io_upload_waitReq); end
        checks++; if (io_ddr_rd !== 1'b0) begin failures++; $display("FAIL midrst_ddr_rd got=%b exp=0", io_ddr_rd); end
        checks++; if (io_ddr_addr !== 32'h0) begin failures++; $display("FAIL midrst_ddr_addr got=%h exp=0", io_ddr_addr); end
        @(negedge clock);
        #1 reset = 1'b0;
        ret_data = 64'hDEAD_BEEF_CAFE_F00D;
        ret_cnt  = 3;
        repeat (5) @(negedge clock);
        #1;
        checks++; if (io_upload_din !== 16'h0) begin failures++; $display("FAIL stray_din got=%h exp=0", io_upload_din); end
        checks++; if (io_upload_waitReq !== 1'b0 || io_ddr_rd !== 1'b0) begin failures++; $display("FAIL stray_state got=%b/%b exp=0/0", io_upload_waitReq, io_ddr_rd); end
        do_read(25'h10, wr0, din, waited, nreq);
        exp = exp_q.pop_front();
        checks++; if (wr0 !== 1'b1 || nreq != 1) begin failures++; $display("FAIL midrst_buf_invalid got=%b/%0d exp=1/1", wr0, nreq); end
        checks++; if (din !== exp) begin failures++; $display("FAIL midrst_refetch_din got=%h exp=%h", din, exp); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_backpressure();
        test_cs_gate();
        test_abort();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
